// File: rtl/alpha_trace_pkg.sv
// Shared types and constants for the retire-trace capture block.
// The record keeps a fixed-width sequence field; the top narrows it to SEQ_W.
package alpha_trace_pkg;

   localparam int PC_W      = 64;
   localparam int DATA_W    = 64;
   localparam int REG_W     = 5;
   localparam int SEQ_MAX_W = 32;

   localparam logic POLICY_DROP_NEWEST      = 1'b0;
   localparam logic POLICY_OVERWRITE_OLDEST = 1'b1;

   localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HALTED  = 2'd1,
      ST_TIMEOUT = 2'd2
   } trace_state_e;

   typedef struct packed {
      logic [PC_W-1:0]      pc;
      logic [DATA_W-1:0]    data;
      logic [REG_W-1:0]     addr;
      logic [SEQ_MAX_W-1:0] seq;
   } trace_rec_t;

   localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/alpha_trace_fifo.sv
// Trace record storage: circular buffer with a separate occupancy count.
// When the buffer is full, it either drops the newest record or evicts the oldest one.
module alpha_trace_fifo
   import alpha_trace_pkg::*;
#(
   parameter int   DEPTH     = 16,
   parameter int   WIDTH     = REC_W,
   parameter logic OVERWRITE = POLICY_DROP_NEWEST
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    push,
   input  logic [WIDTH-1:0]        wdata,
   input  logic                    pop,
   output logic                    valid,
   output logic [WIDTH-1:0]        rdata,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    dropped
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_pop;
   logic             do_write;
   logic             evict;

   assign valid = (count != '0);
   assign rdata = valid ? mem[rd_ptr] : '0;

   // A pop in the same cycle frees a slot, so a full buffer still accepts the push.
   always_comb begin
      full     = (count == (AW + 1)'(DEPTH));
      do_pop   = pop && valid;
      do_write = push && (!full || do_pop || OVERWRITE);
      evict    = push && full && !do_pop && OVERWRITE;
      dropped  = push && full && !do_pop;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // NOTE: non-blocking updates let every register see the pre-edge pointer values.
         if (do_write)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop || evict)
            rd_ptr <= rd_ptr + 1'b1;
         if (do_write && !do_pop && !evict)
            count <= count + 1'b1;
         else if (do_pop && !do_write)
            count <= count - 1'b1;
      end
   end

   // NOTE: storage has no reset; the occupancy count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (do_write)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/alpha_retire_trace.sv
// Retire-trace capture: tags graduated register writes with a sequence number,
// buffers them for readout, and stops capture on halt or on an idle watchdog trip.
module alpha_retire_trace
   import alpha_trace_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 1500,
   parameter int SEQ_W          = 16,
   parameter int OVERWRITE      = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rec_valid_gr,
   input  logic [63:0]            rec_pc_gr,
   input  logic [63:0]            rec_data_gr,
   input  logic [4:0]             rec_addr_gr,
   input  logic                   halt_e1,
   input  logic                   clear_xx,
   output logic                   rd_valid_xx,
   input  logic                   rd_ready_xx,
   output logic [63:0]            rd_pc_xx,
   output logic [63:0]            rd_data_xx,
   output logic [4:0]             rd_addr_xx,
   output logic [SEQ_W-1:0]       rd_seq_xx,
   output logic [$clog2(DEPTH):0] fill_xx,
   output logic [15:0]            drop_cnt_xx,
   output logic [1:0]             state_xx,
   output logic                   timeout_xx
);

   localparam int IDLE_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
   localparam logic FIFO_POLICY = (OVERWRITE != 0) ? POLICY_OVERWRITE_OLDEST : POLICY_DROP_NEWEST;

   trace_state_e      state;
   logic [SEQ_W-1:0]  seq;
   logic [IDLE_W-1:0] idle_cnt;
   logic              capture;
   logic              fifo_dropped;
   trace_rec_t        rec_in;
   trace_rec_t        head;
   logic [REC_W-1:0]  head_bits;

   assign capture = (state == ST_RUN) && rec_valid_gr && !clear_xx;

   always_comb begin
      // NOTE: default-first assignment keeps this block free of inferred latches.
      rec_in      = '0;
      rec_in.pc   = rec_pc_gr;
      rec_in.data = rec_data_gr;
      rec_in.addr = rec_addr_gr;
      rec_in.seq  = SEQ_MAX_W'(seq);
   end

   alpha_trace_fifo #(
      .DEPTH     (DEPTH),
      .WIDTH     (REC_W),
      .OVERWRITE (FIFO_POLICY)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear_xx),
      .push    (capture),
      .wdata   (rec_in),
      .pop     (rd_ready_xx),
      .valid   (rd_valid_xx),
      .rdata   (head_bits),
      .count   (fill_xx),
      .dropped (fifo_dropped)
   );

   assign head       = trace_rec_t'(head_bits);
   assign rd_pc_xx   = head.pc;
   assign rd_data_xx = head.data;
   assign rd_addr_xx = head.addr;
   assign rd_seq_xx  = SEQ_W'(head.seq);
   assign state_xx   = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_RUN;
         seq         <= '0;
         idle_cnt    <= '0;
         drop_cnt_xx <= '0;
         timeout_xx  <= 1'b0;
      end else if (clear_xx) begin
         state       <= ST_RUN;
         seq         <= '0;
         idle_cnt    <= '0;
         drop_cnt_xx <= '0;
         timeout_xx  <= 1'b0;
      end else begin
         // Sequence advances for dropped records too, so gaps in rd_seq_xx reveal loss.
         if (capture)
            seq <= seq + 1'b1;
         if (fifo_dropped && (drop_cnt_xx != DROP_CNT_MAX))
            drop_cnt_xx <= drop_cnt_xx + 1'b1;
         case (state)
            ST_RUN: begin
               if (halt_e1)
                  state <= ST_HALTED;
               else if (rec_valid_gr)
                  idle_cnt <= '0;
               else if ((TIMEOUT_CYCLES != 0) && (idle_cnt == IDLE_LAST)) begin
                  state      <= ST_TIMEOUT;
                  timeout_xx <= 1'b1;
               end else
                  idle_cnt <= idle_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alpha_retire_trace.sv
// Directed bench: two DEPTH=4 instances that receive the same stimulus, one
// dropping the newest record and one overwriting the oldest, with TIMEOUT_CYCLES=10.
module tb_alpha_retire_trace;

   logic        clk = 1'b0;
   logic        reset;
   logic        rec_valid_gr;
   logic [63:0] rec_pc_gr;
   logic [63:0] rec_data_gr;
   logic [4:0]  rec_addr_gr;
   logic        halt_e1;
   logic        clear_xx;
   logic        rd_ready_xx;

   logic        rd_valid_a, rd_valid_b;
   logic [63:0] rd_pc_a, rd_pc_b;
   logic [63:0] rd_data_a, rd_data_b;
   logic [4:0]  rd_addr_a, rd_addr_b;
   logic [15:0] rd_seq_a, rd_seq_b;
   logic [2:0]  fill_a, fill_b;
   logic [15:0] drop_a, drop_b;
   logic [1:0]  state_a, state_b;
   logic        tmo_a, tmo_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alpha_retire_trace #(.DEPTH(4), .TIMEOUT_CYCLES(10), .SEQ_W(16), .OVERWRITE(0)) dut_a (
      .clk(clk), .reset(reset), .rec_valid_gr(rec_valid_gr), .rec_pc_gr(rec_pc_gr),
      .rec_data_gr(rec_data_gr), .rec_addr_gr(rec_addr_gr), .halt_e1(halt_e1),
      .clear_xx(clear_xx), .rd_valid_xx(rd_valid_a), .rd_ready_xx(rd_ready_xx),
      .rd_pc_xx(rd_pc_a), .rd_data_xx(rd_data_a), .rd_addr_xx(rd_addr_a),
      .rd_seq_xx(rd_seq_a), .fill_xx(fill_a), .drop_cnt_xx(drop_a),
      .state_xx(state_a), .timeout_xx(tmo_a)
   );

   alpha_retire_trace #(.DEPTH(4), .TIMEOUT_CYCLES(10), .SEQ_W(16), .OVERWRITE(1)) dut_b (
      .clk(clk), .reset(reset), .rec_valid_gr(rec_valid_gr), .rec_pc_gr(rec_pc_gr),
      .rec_data_gr(rec_data_gr), .rec_addr_gr(rec_addr_gr), .halt_e1(halt_e1),
      .clear_xx(clear_xx), .rd_valid_xx(rd_valid_b), .rd_ready_xx(rd_ready_xx),
      .rd_pc_xx(rd_pc_b), .rd_data_xx(rd_data_b), .rd_addr_xx(rd_addr_b),
      .rd_seq_xx(rd_seq_b), .fill_xx(fill_b), .drop_cnt_xx(drop_b),
      .state_xx(state_b), .timeout_xx(tmo_b)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_clear();
      clear_xx = 1'b1;
      step();
      clear_xx = 1'b0;
   endtask

   task automatic offer(input logic [63:0] pc, input logic [63:0] data, input logic [4:0] addr);
      rec_valid_gr = 1'b1;
      rec_pc_gr    = pc;
      rec_data_gr  = data;
      rec_addr_gr  = addr;
      step();
      rec_valid_gr = 1'b0;
   endtask

   task automatic pop_one();
      rd_ready_xx = 1'b1;
      step();
      rd_ready_xx = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      total++; if (state_a !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state_a); end
      total++; if (fill_a !== 3'd0) begin bad++; $display("FAIL rst_fill: got %0d want 0", fill_a); end
      total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", rd_valid_a); end
      total++; if (rd_pc_a !== 64'h0) begin bad++; $display("FAIL rst_pc: got %0h want 0", rd_pc_a); end
      total++; if (rd_seq_a !== 16'h0) begin bad++; $display("FAIL rst_seq: got %0h want 0", rd_seq_a); end
      total++; if (drop_a !== 16'h0) begin bad++; $display("FAIL rst_drop: got %0d want 0", drop_a); end
      total++; if (tmo_a !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %0b want 0", tmo_a); end
      total++; if (fill_b !== 3'd0) begin bad++; $display("FAIL rst_fill_b: got %0d want 0", fill_b); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_single();
      do_clear();
      total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL single_pre_valid: got %0b want 0", rd_valid_a); end
      offer(64'h1000, 64'h2A, 5'd3);
      total++; if (rd_valid_a !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", rd_valid_a); end
      total++; if (rd_pc_a !== 64'h1000) begin bad++; $display("FAIL single_pc: got %0h want 1000", rd_pc_a); end
      total++; if (rd_data_a !== 64'h2A) begin bad++; $display("FAIL single_data: got %0h want 2a", rd_data_a); end
      total++; if (rd_addr_a !== 5'd3) begin bad++; $display("FAIL single_addr: got %0d want 3", rd_addr_a); end
      total++; if (rd_seq_a !== 16'd0) begin bad++; $display("FAIL single_seq: got %0d want 0", rd_seq_a); end
      total++; if (fill_a !== 3'd1) begin bad++; $display("FAIL single_fill: got %0d want 1", fill_a); end
      step();
      total++; if (rd_pc_a !== 64'h1000 || rd_valid_a !== 1'b1) begin bad++; $display("FAIL single_hold: got pc=%0h v=%0b want pc=1000 v=1", rd_pc_a, rd_valid_a); end
      pop_one();
      total++; if (fill_a !== 3'd0) begin bad++; $display("FAIL single_pop_fill: got %0d want 0", fill_a); end
      total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL single_pop_valid: got %0b want 0", rd_valid_a); end
   endtask

   task automatic test_full();
      do_clear();
      for (int i = 0; i < 6; i++)
         offer(64'h100 + 64'(i), 64'hD0 + 64'(i), 5'(i));
      total++; if (fill_a !== 3'd4) begin bad++; $display("FAIL full_fill_a: got %0d want 4", fill_a); end
      total++; if (drop_a !== 16'd2) begin bad++; $display("FAIL full_drop_a: got %0d want 2", drop_a); end
      total++; if (fill_b !== 3'd4) begin bad++; $display("FAIL full_fill_b: got %0d want 4", fill_b); end
      total++; if (drop_b !== 16'd2) begin bad++; $display("FAIL full_drop_b: got %0d want 2", drop_b); end
      for (int i = 0; i < 4; i++) begin
         total++; if (rd_seq_a !== 16'(i)) begin bad++; $display("FAIL full_seq_a[%0d]: got %0d want %0d", i, rd_seq_a, i); end
         total++; if (rd_seq_b !== 16'(i + 2)) begin bad++; $display("FAIL full_seq_b[%0d]: got %0d want %0d", i, rd_seq_b, i + 2); end
         total++; if (rd_pc_b !== 64'h100 + 64'(i + 2)) begin bad++; $display("FAIL full_pc_b[%0d]: got %0h want %0h", i, rd_pc_b, 64'h100 + 64'(i + 2)); end
         pop_one();
      end
      total++; if (fill_a !== 3'd0 || fill_b !== 3'd0) begin bad++; $display("FAIL full_drain: got a=%0d b=%0d want 0", fill_a, fill_b); end
      // Clear wins over a record offered in the same cycle.
      rec_valid_gr = 1'b1;
      clear_xx     = 1'b1;
      step();
      rec_valid_gr = 1'b0;
      clear_xx     = 1'b0;
      total++; if (fill_a !== 3'd0) begin bad++; $display("FAIL clr_fill: got %0d want 0", fill_a); end
      total++; if (drop_a !== 16'd0 || drop_b !== 16'd0) begin bad++; $display("FAIL clr_drop: got a=%0d b=%0d want 0", drop_a, drop_b); end
      offer(64'h180, 64'h1, 5'd1);
      total++; if (rd_seq_a !== 16'd0) begin bad++; $display("FAIL clr_seq: got %0d want 0", rd_seq_a); end
      pop_one();
   endtask

   task automatic test_push_pop_full_and_reset();
      do_clear();
      for (int i = 0; i < 4; i++)
         offer(64'h200 + 64'(i), 64'(i), 5'(i));
      total++; if (fill_a !== 3'd4) begin bad++; $display("FAIL pp_prefill: got %0d want 4", fill_a); end
      rec_valid_gr = 1'b1;
      rec_pc_gr    = 64'h204;
      rd_ready_xx  = 1'b1;
      step();
      rec_valid_gr = 1'b0;
      rd_ready_xx  = 1'b0;
      total++; if (fill_a !== 3'd4 || fill_b !== 3'd4) begin bad++; $display("FAIL pp_fill: got a=%0d b=%0d want 4", fill_a, fill_b); end
      total++; if (drop_a !== 16'd0 || drop_b !== 16'd0) begin bad++; $display("FAIL pp_drop: got a=%0d b=%0d want 0", drop_a, drop_b); end
      total++; if (rd_seq_a !== 16'd1 || rd_seq_b !== 16'd1) begin bad++; $display("FAIL pp_head: got a=%0d b=%0d want 1", rd_seq_a, rd_seq_b); end
      offer(64'h205, 64'h5, 5'd5);
      reset = 1'b1;
      #1;
      total++; if (fill_a !== 3'd0 || fill_b !== 3'd0) begin bad++; $display("FAIL arst_fill: got a=%0d b=%0d want 0", fill_a, fill_b); end
      total++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin bad++; $display("FAIL arst_valid: got a=%0b b=%0b want 0", rd_valid_a, rd_valid_b); end
      total++; if (drop_a !== 16'd0) begin bad++; $display("FAIL arst_drop: got %0d want 0", drop_a); end
      total++; if (rd_pc_a !== 64'h0) begin bad++; $display("FAIL arst_pc: got %0h want 0", rd_pc_a); end
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_halt();
      do_clear();
      offer(64'h300, 64'h0, 5'd1);
      halt_e1 = 1'b1;
      offer(64'h301, 64'h1, 5'd2);
      halt_e1 = 1'b0;
      total++; if (state_a !== 2'd1) begin bad++; $display("FAIL halt_state: got %0d want 1", state_a); end
      offer(64'h302, 64'h2, 5'd3);
      offer(64'h303, 64'h3, 5'd4);
      total++; if (fill_a !== 3'd2) begin bad++; $display("FAIL halt_fill: got %0d want 2", fill_a); end
      repeat (12) step();
      total++; if (state_a !== 2'd1 || tmo_a !== 1'b0) begin bad++; $display("FAIL halt_stay: got st=%0d to=%0b want st=1 to=0", state_a, tmo_a); end
      total++; if (rd_seq_a !== 16'd0) begin bad++; $display("FAIL halt_seq0: got %0d want 0", rd_seq_a); end
      pop_one();
      total++; if (rd_seq_a !== 16'd1 || rd_pc_a !== 64'h301) begin bad++; $display("FAIL halt_seq1: got seq=%0d pc=%0h want seq=1 pc=301", rd_seq_a, rd_pc_a); end
      pop_one();
      total++; if (fill_a !== 3'd0) begin bad++; $display("FAIL halt_drain: got %0d want 0", fill_a); end
   endtask

   task automatic test_halt_over_timeout();
      do_clear();
      repeat (9) step();
      halt_e1 = 1'b1;
      step();
      halt_e1 = 1'b0;
      total++; if (state_a !== 2'd1) begin bad++; $display("FAIL hvt_state: got %0d want 1", state_a); end
      total++; if (tmo_a !== 1'b0) begin bad++; $display("FAIL hvt_timeout: got %0b want 0", tmo_a); end
   endtask

   task automatic test_timeout();
      do_clear();
      repeat (9) step();
      total++; if (state_a !== 2'd0 || tmo_a !== 1'b0) begin bad++; $display("FAIL tmo_early: got st=%0d to=%0b want st=0 to=0", state_a, tmo_a); end
      step();
      total++; if (state_a !== 2'd2) begin bad++; $display("FAIL tmo_state: got %0d want 2", state_a); end
      total++; if (tmo_a !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %0b want 1", tmo_a); end
      offer(64'h400, 64'h0, 5'd0);
      total++; if (fill_a !== 3'd0) begin bad++; $display("FAIL tmo_ignore: got %0d want 0", fill_a); end
      do_clear();
      total++; if (state_a !== 2'd0 || tmo_a !== 1'b0) begin bad++; $display("FAIL tmo_clear: got st=%0d to=%0b want st=0 to=0", state_a, tmo_a); end
      total++; if (drop_a !== 16'd0 || fill_a !== 3'd0) begin bad++; $display("FAIL tmo_clear_cnt: got drop=%0d fill=%0d want 0", drop_a, fill_a); end
      offer(64'h401, 64'h1, 5'd1);
      total++; if (rd_seq_a !== 16'd0) begin bad++; $display("FAIL tmo_clear_seq: got %0d want 0", rd_seq_a); end
   endtask

   initial begin
      reset        = 1'b1;
      rec_valid_gr = 1'b0;
      rec_pc_gr    = '0;
      rec_data_gr  = '0;
      rec_addr_gr  = '0;
      halt_e1      = 1'b0;
      clear_xx     = 1'b0;
      rd_ready_xx  = 1'b0;
      test_reset();
      test_single();
      test_full();
      test_push_pop_full_and_reset();
      test_halt();
      test_halt_over_timeout();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alpha_retire_trace.md
ALPHA_RETIRE_TRACE -- requirements
Module: alpha_retire_trace

Interface
REQ-001 SHALL have parameter DEPTH, default 16, trace buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1500, idle cycles before watchdog trip (0 = disabled).
REQ-003 SHALL have parameter SEQ_W, default 16, sequence-number width.
REQ-004 SHALL have parameter OVERWRITE, default 0, full-buffer policy (0 = drop newest, 1 = overwrite oldest).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  core clock; reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: rec_valid_gr  in  1  graduated register write offered; rec_pc_gr  in  64  instruction PC; rec_data_gr  in  64  write data; rec_addr_gr  in  5  destination register.
REQ-007 SHALL have ports: halt_e1  in  1  CALL_PAL seen, stop capture; clear_xx  in  1  synchronous flush and restart.
REQ-008 SHALL have ports: rd_valid_xx  out  1  head entry available; rd_ready_xx  in  1  consumer pop; rd_pc_xx  out  64; rd_data_xx  out  64; rd_addr_xx  out  5; rd_seq_xx  out  SEQ_W  head sequence number.
REQ-009 SHALL have ports: fill_xx  out  clog2(DEPTH)+1  occupancy; drop_cnt_xx  out  16  lost records; state_xx  out  2  FSM state; timeout_xx  out  1  watchdog tripped.

Function
REQ-010 SHALL implement states RUN(0), HALTED(1), TIMEOUT(2); capture only in RUN.
REQ-011 SHALL, in RUN, go to HALTED the cycle after halt_e1=1; a record offered in that same cycle SHALL still be captured.
REQ-012 SHALL count idle RUN cycles (no rec_valid_gr); the counter resets to 0 on rec_valid_gr or clear_xx; reaching TIMEOUT_CYCLES SHALL enter TIMEOUT and set timeout_xx; halt_e1 has priority over timeout in the same cycle.
REQ-013 SHALL leave HALTED/TIMEOUT only via clear_xx or reset; readout continues in every state.
REQ-014 SHALL assign each offered RUN record the current seq value, then increment seq mod 2^SEQ_W, whether stored or dropped, so gaps expose loss.
REQ-015 SHALL present a pushed record on rd_* with rd_valid_xx=1 one cycle after push into an empty buffer (registered storage, no bypass).
REQ-016 SHALL pop the head when rd_valid_xx & rd_ready_xx; rd_* SHALL hold stable while rd_valid_xx=1 and rd_ready_xx=0.
REQ-017 SHALL, when full and OVERWRITE=0 with no pop, drop the new record and increment drop_cnt_xx.
REQ-018 SHALL, when full and OVERWRITE=1 with no pop, discard the oldest entry, store the new one, increment drop_cnt_xx; fill stays DEPTH.
REQ-019 SHALL, when full with simultaneous push and pop, accept the push in both modes with no drop.
REQ-020 SHALL saturate drop_cnt_xx at 16'hFFFF.
REQ-021 SHALL give clear_xx priority over all events: empty buffer, seq=0, drop_cnt=0, idle counter=0, timeout_xx=0, state RUN, next cycle.
REQ-022 SHALL wrap read/write pointers modulo DEPTH with a separate occupancy count distinguishing full from empty.

Reset
REQ-023 SHALL on reset asynchronously set: state RUN, fill 0, rd_valid_xx 0, rd_pc/data/addr/seq 0, drop_cnt 0, timeout_xx 0, seq 0, idle counter 0.
REQ-024 SHALL on reset mid-operation discard all buffered entries; no storage contents need be cleared.

Structure
REQ-025 SHALL place the trace record struct (pc, data, addr, seq), the state enum and the policy constants in package alpha_trace_pkg.
REQ-026 SHALL implement storage and pointers in one sub-module alpha_trace_fifo (DEPTH, record width, overwrite enable).

Verification
REQ-027 Empty buffer, one record PC=0x1000 data=0x2A addr=3 -> rd_valid_xx=1 next cycle, rd_seq_xx=0, fill_xx=1.
REQ-028 DEPTH=4, OVERWRITE=0, 6 records no pops -> fill=4, drop_cnt=2, popped seqs 0,1,2,3.
REQ-029 DEPTH=4, OVERWRITE=1, 6 records no pops -> fill=4, drop_cnt=2, popped seqs 2,3,4,5.
REQ-030 Record and halt_e1 same cycle, further records -> record captured, state_xx=1, later records ignored, seq frozen.
REQ-031 TIMEOUT_CYCLES=10, no records -> state_xx=2, timeout_xx=1 after 10 idle cycles; clear_xx -> RUN, all counters 0.
REQ-032 Full buffer, push+pop same cycle, then reset asserted mid-stream -> no drop; after reset fill=0, rd_valid_xx=0 immediately.
